// File: rtl/sha2_padder.sv
// Streaming SHA-2 padder: packs message words into a 16-word block and appends the
// FIPS 180-4 padding (0x80 marker, zero fill, 2*W-bit length) itself.
module sha2_padder #(
    parameter int W = 64,
    localparam int NB_W  = $clog2(W/8) + 1,
    localparam int BLK_W = 16 * W,
    localparam int LEN_W = 2 * W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    input  logic [NB_W-1:0]  in_nbytes,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] blk,
    output logic             blk_last,
    output logic [3:0]       idx
);

    typedef enum logic [2:0] {S_LOAD, S_PAD, S_ZERO, S_LEN, S_FULL} state_t;

    state_t             state, state_n, resume, resume_n;
    logic               pad_wrap, pad_wrap_n;
    logic [LEN_W-1:0]   len, len_n;
    logic               blk_valid_n, blk_last_n;
    logic               wr_en;
    logic [W-1:0]       wr_data;
    logic [W-1:0]       keep_mask, marker, pad_word;
    logic               last_slot;

    // Partial last word: keep the valid leading bytes and drop the 0x80 marker right after them.
    assign keep_mask = ~({W{1'b1}} >> {in_nbytes, 3'b000});
    assign marker    = {8'h80, {(W-8){1'b0}}} >> {in_nbytes, 3'b000};
    assign pad_word  = (in_data & keep_mask) | marker;

    assign in_ready  = (state == S_LOAD) && !blk_valid;
    assign last_slot = (idx == 4'd15);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        resume_n    = resume;
        pad_wrap_n  = pad_wrap;
        len_n       = len;
        blk_valid_n = blk_valid;
        blk_last_n  = blk_last;
        wr_en       = 1'b0;
        wr_data     = '0;

        case (state)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    if (!in_last) begin
                        wr_data = in_data;
                        len_n   = len + LEN_W'(W);
                    end else if (in_nbytes < NB_W'(W/8)) begin
                        wr_data    = pad_word;
                        len_n      = len + LEN_W'({in_nbytes, 3'b000});
                        pad_wrap_n = (idx == 4'd14);
                        state_n    = S_ZERO;
                    end else begin
                        wr_data = in_data;
                        len_n   = len + LEN_W'(W);
                        state_n = S_PAD;
                    end
                end
            end
            S_PAD: begin
                wr_en      = 1'b1;
                wr_data    = {8'h80, {(W-8){1'b0}}};
                pad_wrap_n = (idx == 4'd14);
                state_n    = S_ZERO;
            end
            S_ZERO: begin
                // Length only fits if the marker landed at slot 13 or earlier in this block.
                if (!pad_wrap && idx == 4'd14) begin
                    state_n = S_LEN;
                end else begin
                    wr_en = 1'b1;
                    if (last_slot) pad_wrap_n = 1'b0;
                end
            end
            S_LEN: begin
                wr_en   = 1'b1;
                wr_data = last_slot ? len[W-1:0] : len[LEN_W-1:W];
                if (last_slot) begin
                    blk_last_n = 1'b1;
                    state_n    = S_LOAD;
                end
            end
            S_FULL: begin
                if (blk_ready) begin
                    blk_valid_n = 1'b0;
                    state_n     = resume;
                    if (blk_last) begin
                        blk_last_n = 1'b0;
                        len_n      = '0;
                    end
                end
            end
            default: state_n = S_LOAD;
        endcase

        // Filling slot 15 always closes the block; the state computed above is where we resume.
        if (wr_en && last_slot) begin
            resume_n    = state_n;
            state_n     = S_FULL;
            blk_valid_n = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_LOAD;
            resume   <= S_LOAD;
            pad_wrap <= 1'b0;
        end else if (clr) begin
            state    <= S_LOAD;
            resume   <= S_LOAD;
            pad_wrap <= 1'b0;
        end else begin
            state    <= state_n;
            resume   <= resume_n;
            pad_wrap <= pad_wrap_n;
        end
    end

    // NOTE: the block register is cleared on reset/clr because abort must leave blk observably zero.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            idx       <= '0;
            len       <= '0;
            blk       <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else if (clr) begin
            idx       <= '0;
            len       <= '0;
            blk       <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            len       <= len_n;
            blk_valid <= blk_valid_n;
            blk_last  <= blk_last_n;
            if (wr_en) begin
                blk[int'(idx)*W +: W] <= wr_data;
                idx                   <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sha2_padder.sv
// Bench for sha2_padder at W=32 and W=64: messages are padded by a byte-level
// reference model and the emitted blocks are compared word by word.
module tb_sha2_padder;

    logic clk = 1'b0;
    logic rst_b, clr;
    always #5 clk = ~clk;

    logic         v32, r32, l32, bv32, br32, bl32;
    logic [31:0]  d32;
    logic [2:0]   nb32;
    logic [511:0] blk32;
    logic [3:0]   idx32;

    logic          v64, r64, l64, bv64, br64, bl64;
    logic [63:0]   d64;
    logic [3:0]    nb64;
    logic [1023:0] blk64;
    logic [3:0]    idx64;

    sha2_padder #(.W(32)) u32 (
        .clk(clk), .rst_b(rst_b), .clr(clr),
        .in_valid(v32), .in_ready(r32), .in_data(d32), .in_last(l32), .in_nbytes(nb32),
        .blk_valid(bv32), .blk_ready(br32), .blk(blk32), .blk_last(bl32), .idx(idx32)
    );

    sha2_padder #(.W(64)) u64 (
        .clk(clk), .rst_b(rst_b), .clr(clr),
        .in_valid(v64), .in_ready(r64), .in_data(d64), .in_last(l64), .in_nbytes(nb64),
        .blk_valid(bv64), .blk_ready(br64), .blk(blk64), .blk_last(bl64), .idx(idx64)
    );

    typedef struct {
        logic [63:0] data;
        bit          last;
        int          nb;
    } in_word_t;

    int                tests  = 0;
    int                failed = 0;
    byte unsigned      msg_q[$];
    logic [63:0]       got[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input bit w64, input int i);
        return w64 ? blk64[i*64 +: 64] : {32'b0, blk32[i*32 +: 32]};
    endfunction

    task automatic drive(input bit w64, input bit vld, input logic [63:0] data,
                         input bit last, input int nb, input bit rdy);
        if (w64) begin
            v64 = vld; d64 = data; l64 = last; nb64 = 4'(nb); br64 = rdy;
            v32 = 1'b0; br32 = 1'b0;
        end else begin
            v32 = vld; d32 = data[31:0]; l32 = last; nb32 = 3'(nb); br32 = rdy;
            v64 = 1'b0; br64 = 1'b0;
        end
    endtask

    // Sends msg_q and checks every emitted block against the padded byte stream.
    task automatic run_msg(input bit w64, input int stall_first, input bit rand_gaps,
                           input bit empty_tail, input string tag);
        int           wb, n, nfull, rem, nblk, budget;
        int           wi, bi, cyc, stall, lat, k;
        bit           tail, armed, lat_done, lat_chk, holding;
        bit           ir, bv, bl, vld, rdy;
        logic [3:0]   ix;
        logic [1023:0] cb, held;
        logic [127:0] bitlen;
        logic [63:0]  acc;
        in_word_t     w;
        in_word_t     in_q[$];
        logic [63:0]  exp_q[$];
        byte unsigned p[$];

        wb    = w64 ? 8 : 4;
        n     = msg_q.size();
        nfull = n / wb;
        rem   = n % wb;
        tail  = (rem != 0) || (n == 0) || empty_tail;

        for (int i = 0; i < nfull; i++) begin
            w.data = '0;
            for (int b = 0; b < wb; b++) w.data = (w.data << 8) | 64'(msg_q[i*wb + b]);
            w.last = !tail && (i == nfull - 1);
            w.nb   = wb;
            in_q.push_back(w);
        end
        if (tail) begin
            w.data = '0;
            for (int b = 0; b < wb; b++)
                w.data = (w.data << 8) | 64'((b < rem) ? msg_q[nfull*wb + b] : 8'($urandom));
            w.last = 1'b1;
            w.nb   = rem;
            in_q.push_back(w);
        end

        foreach (msg_q[i]) p.push_back(msg_q[i]);
        p.push_back(8'h80);
        while (p.size() % (16*wb) != 14*wb) p.push_back(8'h00);
        bitlen = 128'(n) << 3;
        for (int i = 0; i < 2*wb; i++) p.push_back(bitlen[8*(2*wb-1-i) +: 8]);
        for (int i = 0; i < p.size() / wb; i++) begin
            acc = '0;
            for (int b = 0; b < wb; b++) acc = (acc << 8) | 64'(p[i*wb + b]);
            exp_q.push_back(acc);
        end
        nblk   = exp_q.size() / 16;
        budget = 40 * (in_q.size() + 16*nblk) + stall_first + 200;

        wi = 0; bi = 0; cyc = 0; stall = stall_first; lat = 0; k = 0;
        armed = 0; lat_done = 0; lat_chk = 0; holding = 0; held = '0;

        @(negedge clk);
        while (bi < nblk && cyc < budget) begin
            ir = w64 ? r64 : r32;
            bv = w64 ? bv64 : bv32;
            bl = w64 ? bl64 : bl32;
            ix = w64 ? idx64 : idx32;
            cb = w64 ? blk64 : {512'b0, blk32};

            vld = (wi < in_q.size()) && (!rand_gaps || $urandom_range(3) != 0);
            if (bv && stall > 0) begin
                rdy = 1'b0;
                stall--;
                if (holding) check({tag, " blk stable"}, 64'(cb === held), 64'd1);
                check({tag, " in_ready held low"}, 64'(ir), 64'd0);
                held    = cb;
                holding = 1'b1;
            end else begin
                rdy = rand_gaps ? ($urandom_range(2) != 0) : 1'b1;
            end

            if (armed && bv && !lat_done) begin
                lat_done = 1'b1;
                if (lat_chk) check({tag, " latency"}, 64'(lat), 64'(16 - k));
            end

            if (vld) drive(w64, 1'b1, in_q[wi].data, in_q[wi].last, in_q[wi].nb, rdy);
            else     drive(w64, 1'b0, 64'(0), 1'b0, 0, rdy);

            if (vld && ir) begin
                if (in_q[wi].last) begin
                    armed   = 1'b1;
                    lat     = -1;
                    k       = int'(ix);
                    lat_chk = (in_q[wi].nb < wb) && (ix <= 4'd13);
                end
                wi++;
            end

            if (bv && rdy) begin
                for (int i = 0; i < 16; i++) begin
                    got[i] = word_of(w64, i);
                    check($sformatf("%s blk%0d w%0d", tag, bi, i), got[i], exp_q[bi*16 + i]);
                end
                check($sformatf("%s blk%0d last", tag, bi), 64'(bl), 64'(bi == nblk - 1));
                bi++;
                holding = 1'b0;
            end

            @(posedge clk);
            if (armed) lat++;
            cyc++;
            @(negedge clk);
        end
        if (bi < nblk) check({tag, " timeout blocks"}, 64'(bi), 64'(nblk));
        check({tag, " words consumed"}, 64'(wi), 64'(in_q.size()));
        drive(w64, 1'b0, 64'(0), 1'b0, 0, 1'b0);
    endtask

    task automatic set_msg_random(input int n);
        msg_q.delete();
        repeat (n) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        int rises;
        int lens[6];

        rst_b = 1'b0;
        clr   = 1'b0;
        drive(1'b0, 1'b0, 64'(0), 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 64'(0), 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        check("rst idx32", 64'(idx32), 64'd0);
        check("rst idx64", 64'(idx64), 64'd0);
        check("rst blk_valid32", 64'(bv32), 64'd0);
        check("rst blk_valid64", 64'(bv64), 64'd0);
        check("rst in_ready32", 64'(r32), 64'd1);
        check("rst in_ready64", 64'(r64), 64'd1);
        check("rst blk32 zero", 64'(|blk32), 64'd0);
        check("rst blk64 zero", 64'(|blk64), 64'd0);
        check("rst blk_last64", 64'(bl64), 64'd0);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0, 1'b0, 1'b0, "abc");
        check("abc w0", got[0], 64'h61626380);
        check("abc w15", got[15], 64'h18);

        msg_q.delete();
        run_msg(1'b1, 0, 1'b0, 1'b0, "empty64");
        check("empty64 w0", got[0], 64'h8000_0000_0000_0000);
        check("empty64 w15", got[15], 64'h0);

        set_msg_random(14*4);
        run_msg(1'b0, 0, 1'b0, 1'b0, "14w32");
        check("14w32 w14", got[14], 64'h0);
        check("14w32 w15", got[15], 64'h1C0);

        set_msg_random(17*8);
        run_msg(1'b1, 0, 1'b0, 1'b0, "17w64");
        check("17w64 w1", got[1], 64'h8000_0000_0000_0000);
        check("17w64 w15", got[15], 64'h440);

        set_msg_random(20*4);
        run_msg(1'b0, 5, 1'b0, 1'b0, "stall");

        set_msg_random(8);
        run_msg(1'b0, 0, 1'b0, 1'b1, "empty tail");

        lens = '{55, 56, 58, 61, 63, 64};
        foreach (lens[i]) begin
            set_msg_random(lens[i]);
            run_msg(1'b0, 0, 1'b0, 1'b0, $sformatf("len%0d", lens[i]));
        end

        // Abort after five accepted words.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 64'($urandom), 1'b0, 4, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 64'(0), 1'b0, 0, 1'b0);
        check("clr idx before", 64'(idx32), 64'd5);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr idx", 64'(idx32), 64'd0);
        check("clr blk zero", 64'(|blk32), 64'd0);
        check("clr blk_valid", 64'(bv32), 64'd0);
        check("clr in_ready", 64'(r32), 64'd1);
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(1'b0, 0, 1'b0, 1'b0, "abc after clr");
        check("abc after clr w0", got[0], 64'h61626380);
        check("abc after clr w15", got[15], 64'h18);

        // Abort in the middle of padding: nothing may be emitted.
        drive(1'b0, 1'b1, 64'h11223344, 1'b1, 2, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'(0), 1'b0, 0, 1'b1);
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        rises = 0;
        repeat (20) begin
            @(negedge clk);
            if (bv32) rises++;
        end
        check("clr mid-pad no emit", 64'(rises), 64'd0);
        check("clr mid-pad idx", 64'(idx32), 64'd0);

        // Asynchronous reset between clock edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 8, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 1'b0, 64'(0), 1'b0, 0, 1'b0);
        #2 rst_b = 1'b0;
        #1 check("async rst idx64", 64'(idx64), 64'd0);
        check("async rst blk64 zero", 64'(|blk64), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 24; t++) begin
            set_msg_random($urandom_range(150));
            run_msg(1'($urandom_range(1)), $urandom_range(3), 1'b1, 1'($urandom_range(1)),
                    $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
